fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch front end that feeds the decode stage of the 5-stage core.
//  - Generates the sequential PC stream and issues in-order requests to instruction memory.
//  - Holds returned instructions, each with its PC, in a DEPTH-entry FIFO.
//  - Presents the FIFO head to the IF/ID boundary.
//  - On an execute-stage redirect (PCSrcE) it empties the FIFO, discards in-flight
//    responses and restarts fetch at PCTargetE.
// PARAMETERS
//  XLEN      32   address/PC width
//  DEPTH     4    FIFO entries (power of 2, >=2); also bounds entries+outstanding requests
//  RESET_PC  0    first fetch address after reset
// PORTS
//  clk          in   1     clock
//  reset        in   1     synchronous, active-high reset
//  PCSrcE       in   1     redirect from execute stage (branch/jump taken)
//  PCTargetE    in   XLEN  redirect target
//  StallD       in   1     decode stalled; head is not consumed
//  imem_req     out  1     fetch request valid
//  imem_addr    out  XLEN  fetch address (word aligned)
//  imem_gnt     in   1     request accepted this cycle
//  imem_rvalid  in   1     response valid (in order, >=1 cycle after gnt)
//  imem_rdata   in   32    response instruction
//  InstrD_valid out  1     FIFO head valid
//  InstrD       out  32    head instruction; 32'h00000013 (NOP) when not valid
//  PCD          out  XLEN  head PC; 0 when not valid
//  PCPlus4D     out  XLEN  PCD+4; 4 when not valid
//  empty        out  1     FIFO count == 0
//  full         out  1     FIFO count == DEPTH
// BEHAVIOUR
//  Reset
//   - fetch_pc = resp_pc = RESET_PC; count = outstanding = discard = 0.
//   - imem_req = 0, InstrD_valid = 0, empty = 1, full = 0.
//  Request
//   - imem_req = !reset && !PCSrcE && (count + outstanding < DEPTH); imem_addr = fetch_pc.
//   - Grant (req && gnt): fetch_pc += 4 (mod 2^XLEN), outstanding++.
//  Response
//   - Every rvalid decrements outstanding.
//   - If discard > 0: response dropped, discard--.
//   - Otherwise {resp_pc, imem_rdata} is pushed and resp_pc += 4.
//  Pop
//   - When InstrD_valid && !StallD && !PCSrcE.
//   - Push and pop in the same cycle are both performed; count is unchanged.
//  Latency
//   - Grant at cycle t with rvalid at t+L gives InstrD_valid at t+L+1. There is no bypass.
//  Overflow
//   - Cannot occur: the issue rule reserves a slot per request.
//   - A push while full, or rvalid with outstanding == 0, is a protocol error.
//     The bench asserts on it; RTL ignores such an rvalid.
//  Redirect (PCSrcE = 1), effective at the next edge
//   - count = 0, head/tail reset; any pop or push this cycle is cancelled.
//   - fetch_pc = resp_pc = PCTargetE.
//   - discard = outstanding - imem_rvalid (value before the decrement).
//   - imem_req forced 0 this cycle. Fetch resumes at the target next cycle.
//  Other rules
//   - Redirect while discard > 0 already: discard is recomputed by the same formula,
//     so stale responses are never pushed.
//   - Reset wins over PCSrcE. Reset mid-transfer drops all state; responses that arrive
//     after reset hit outstanding == 0 and are ignored.
//   - PCTargetE[1:0] is ignored and treated as 0.
// TESTING
//  1 Reset, gnt=1, rvalid 1 cycle after gnt, StallD=0
//     -> addr 0,4,8,... in consecutive cycles
//     -> InstrD_valid first at cycle 3 with PCD=0, then one instruction per cycle
//  2 StallD=1 held 10 cycles
//     -> full=1 after DEPTH pushes; imem_req=0 while count+outstanding==4
//     -> head PCD stable
//     -> release: PCs 0,4,8,12 pop in order with no loss
//  3 gnt=0 for 5 cycles
//     -> imem_req stays 1 with addr stable; InstrD_valid drops when the FIFO drains
//  4 Redirect PCTargetE=0x100 with 2 responses outstanding, rvalid latency 3
//     -> both responses discarded
//     -> next InstrD has PCD=0x100
//     -> no PC 0x10/0x14 ever appears
//  5 PCSrcE on the same cycle as rvalid and pop
//     -> no push, no pop, count=0 next cycle
//     -> discard = outstanding-1
//  6 Reset asserted with 3 entries and 1 outstanding
//     -> next cycle empty=1, InstrD=0x00000013
//     -> late rvalid ignored
//     -> fetch restarts at RESET_PC

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: sequential PC fetch with in-order imem requests and a DEPTH-entry {pc, instr} FIFO feeding decode
// Ports: clk/reset (sync, active-high); PCSrcE/PCTargetE redirect; StallD holds the head;
//        imem_req/imem_addr/imem_gnt request side; imem_rvalid/imem_rdata in-order responses;
//        InstrD_valid/InstrD/PCD/PCPlus4D FIFO head; empty/full FIFO status.
module fetch_queue #(
   parameter int XLEN = 32,
   parameter int DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   input  logic            StallD,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            InstrD_valid,
   output logic [31:0]     InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            empty,
   output logic            full
);
   localparam int AW = $clog2(DEPTH);
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
   logic [AW:0]     count_q, count_d, out_q, out_d, disc_q, disc_d;
   logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [AW+1:0]   inflight;
   logic            gnt, rv_ok, push, pop;
   logic [31:0]     instr_mem [DEPTH];
   logic [XLEN-1:0] pc_mem [DEPTH];

   assign InstrD_valid = count_q != '0;
   assign empty        = count_q == '0;
   assign full         = count_q == (AW+1)'(DEPTH);
   assign InstrD       = InstrD_valid ? instr_mem[head_q] : 32'h0000_0013;
   assign PCD          = InstrD_valid ? pc_mem[head_q] : '0;
   assign PCPlus4D     = PCD + XLEN'(4);
   assign imem_addr    = fetch_pc_q;

   always_comb begin
      target     = PCTargetE & ~XLEN'(3);
      inflight   = {1'b0, count_q} + {1'b0, out_q};
      // every request reserves a FIFO slot, so pushes can never overflow
      imem_req   = !reset && !PCSrcE && (inflight < (AW+2)'(DEPTH));
      gnt        = imem_req && imem_gnt;
      // a response with nothing outstanding is a stray and is ignored
      rv_ok      = imem_rvalid && (out_q != '0);
      push       = rv_ok && (disc_q == '0) && !PCSrcE && !full;
      pop        = InstrD_valid && !StallD && !PCSrcE;
      fetch_pc_d = PCSrcE ? target : gnt ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
      resp_pc_d  = PCSrcE ? target : push ? resp_pc_q + XLEN'(4) : resp_pc_q;
      out_d      = out_q + (AW+1)'(gnt) - (AW+1)'(rv_ok);
      // on redirect, everything still in flight after this cycle's response is stale
      disc_d     = PCSrcE ? out_q - (AW+1)'(rv_ok) : disc_q - (AW+1)'(rv_ok && (disc_q != '0));
      count_d    = PCSrcE ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
      head_d     = PCSrcE ? '0 : head_q + AW'(pop);
      tail_d     = PCSrcE ? '0 : tail_q + AW'(push);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         count_q    <= '0;
         out_q      <= '0;
         disc_q     <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         count_q    <= count_d;
         out_q      <= out_d;
         disc_q     <= disc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[tail_q] <= imem_rdata;
         pc_mem[tail_q]    <= resp_pc_q;
      end
   end
endmodule
